conv_out_serializer: RTL and testbench

//  Receiving end of the convolution block's output AXI stream. Accepts one word per handshake,

---
 rtl/conv_out_serializer.sv | 127 ++++++++++++
 tb/tb_conv_out_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_serializer.sv
`timescale 1ns/1ps
// conv_out_serializer
//   Takes one wide word (CONV_CORES results of DATA_WIDTH, core 1 in the LSBs)
//   per slave handshake. Re-emits it as BEATS = CONV_CORES/OUT_LANES narrow
//   beats on the master stream, lowest lane group first. tlast of the word is
//   carried on its final beat. frames_out counts beats sent with tlast and
//   wraps at 16 bits.
// Ports
//   aclk, aresetn    clock (rising edge), asynchronous active-low reset
//   s_axis_*         wide input stream (tdata/tvalid/tlast in, tready out)
//   m_axis_*         narrow output stream (tdata/tvalid/tlast out, tready in)
//   frames_out       wrapping count of output beats sent with tlast
module conv_out_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CONV_CORES = 2,
  parameter int unsigned OUT_LANES  = 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [CONV_CORES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,
  output logic [OUT_LANES*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic [15:0]                      frames_out
);

  localparam int unsigned BEATS = CONV_CORES / OUT_LANES;
  localparam int unsigned LW    = OUT_LANES * DATA_WIDTH;
  localparam int unsigned WW    = CONV_CORES * DATA_WIDTH;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [WW-1:0]    hold_q, hold_d;
  logic             hold_last_q, hold_last_d;
  logic [15:0]      frames_q, frames_d;

  logic             last_beat;
  logic             s_hs;
  logic             m_hs;
  logic [LW-1:0]    lane;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= EMPTY;
      beat_cnt_q  <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      frames_q    <= frames_d;
    end
  end

  // Lane group select, written as a mux to keep index arithmetic constant.
  always_comb begin
    lane = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (beat_cnt_q == CNT_W'(i)) begin
        lane = hold_q[i*LW +: LW];
      end
    end
  end

  always_comb begin
    last_beat     = (beat_cnt_q == LAST_BEAT);
    m_axis_tvalid = (state_q == FULL);
    m_axis_tdata  = (state_q == FULL) ? lane : '0;
    m_axis_tlast  = (state_q == FULL) & hold_last_q & last_beat;
    // Ready on the last beat follows downstream ready so a new word can
    // replace the old one on the same edge.
    s_axis_tready = aresetn & ((state_q == EMPTY) | (last_beat & m_axis_tready));
    s_hs          = s_axis_tvalid & s_axis_tready;
    m_hs          = m_axis_tvalid & m_axis_tready;
    frames_out    = frames_q;
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    frames_d    = frames_q;

    if (m_hs && m_axis_tlast) begin
      frames_d = frames_q + 16'd1;
    end

    case (state_q)
      EMPTY: begin
        if (s_hs) begin
          hold_d      = s_axis_tdata;
          hold_last_d = s_axis_tlast;
          beat_cnt_d  = '0;
          state_d     = FULL;
        end
      end
      FULL: begin
        if (m_hs) begin
          if (!last_beat) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end else if (s_hs) begin
            hold_d      = s_axis_tdata;
            hold_last_d = s_axis_tlast;
            beat_cnt_d  = '0;
          end else begin
            beat_cnt_d = '0;
            state_d    = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_conv_out_serializer.sv
`timescale 1ns/1ps
module tb_conv_out_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Common stimulus, routed to the selected DUT (sel=0: 4x16->16, sel=1: 2x16->32).
  logic        sel = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b1;

  logic        r4, v4, l4, r2, v2, l2;
  logic [15:0] d4, f4, f2;
  logic [31:0] d2;

  conv_out_serializer #(.DATA_WIDTH(16), .CONV_CORES(4), .OUT_LANES(1)) dut4 (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid & ~sel), .s_axis_tlast(s_last),
    .s_axis_tready(r4),
    .m_axis_tdata(d4), .m_axis_tvalid(v4), .m_axis_tlast(l4),
    .m_axis_tready(sel | m_ready), .frames_out(f4)
  );

  conv_out_serializer #(.DATA_WIDTH(16), .CONV_CORES(2), .OUT_LANES(2)) dut2 (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(s_data[31:0]), .s_axis_tvalid(s_valid & sel), .s_axis_tlast(s_last),
    .s_axis_tready(r2),
    .m_axis_tdata(d2), .m_axis_tvalid(v2), .m_axis_tlast(l2),
    .m_axis_tready(~sel | m_ready), .frames_out(f2)
  );

  logic        o_ready, o_valid, o_last;
  logic [31:0] o_data;
  logic [15:0] o_frames;
  assign o_ready  = sel ? r2 : r4;
  assign o_valid  = sel ? v2 : v4;
  assign o_last   = sel ? l2 : l4;
  assign o_data   = sel ? d2 : {16'h0000, d4};
  assign o_frames = sel ? f2 : f4;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: queue of beats still owed downstream for the selected DUT.
  typedef struct { logic [31:0] d; logic l; } beat_t;
  beat_t       q[$];
  logic [15:0] frames[2] = '{16'd0, 16'd0};
  int          accepts = 0;

  task automatic push_word(input logic [63:0] w, input logic last);
    beat_t b;
    int beats = sel ? 1 : 4;
    for (int k = 0; k < beats; k++) begin
      b.d = sel ? w[31:0] : ((w >> (16 * k)) & 64'hFFFF);
      b.l = last && (k == beats - 1);
      q.push_back(b);
    end
  endtask

  // Called at posedge+1 with inputs set; checks at negedge, advances model at posedge.
  task automatic cycle();
    logic exp_valid, exp_ready;
    @(negedge clk);
    exp_valid = (q.size() > 0);
    exp_ready = rst_n && (q.size() == 0 || (q.size() == 1 && m_ready));
    check("s_tready", o_ready, exp_ready);
    check("m_tvalid", o_valid, exp_valid);
    if (exp_valid) begin
      check("m_tdata", o_data, q[0].d);
      check("m_tlast", o_last, q[0].l);
    end
    check("frames_out", o_frames, frames[sel]);
    @(posedge clk);
    if (exp_valid && m_ready) begin
      if (q[0].l) frames[sel] = frames[sel] + 16'd1;
      void'(q.pop_front());
    end
    if (exp_ready && s_valid) begin
      push_word(s_data, s_last);
      accepts++;
    end
    #1;
  endtask

  logic [31:0] cap_d[4];
  logic        cap_l[4];
  logic        cap_r[4];
  logic [6:0]  bp_pat;
  int          guard;
  int          vcount;

  initial begin
    // Reset state
    #3;
    check("rst_tready4", r4, 1'b0);
    check("rst_tvalid4", v4, 1'b0);
    check("rst_tlast4", l4, 1'b0);
    check("rst_tdata4", d4, 16'h0);
    check("rst_frames4", f4, 16'h0);
    check("rst_tvalid2", v2, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single tlast word, downstream always ready
    sel = 1'b0; m_ready = 1'b1;
    s_data = 64'h4444_3333_2222_1111; s_last = 1'b1; s_valid = 1'b1;
    cycle();
    s_valid = 1'b0; s_data = $urandom;
    for (int i = 0; i < 4; i++) begin
      cap_d[i] = o_data; cap_l[i] = o_last; cap_r[i] = o_ready;
      cycle();
    end
    check("t1_beat0", cap_d[0], 32'h1111);
    check("t1_beat1", cap_d[1], 32'h2222);
    check("t1_beat2", cap_d[2], 32'h3333);
    check("t1_beat3", cap_d[3], 32'h4444);
    check("t1_lasts", {cap_l[3], cap_l[2], cap_l[1], cap_l[0]}, 4'b1000);
    check("t1_ready_b123", {cap_r[3], cap_r[2], cap_r[1]}, 3'b100);
    check("t1_frames", o_frames, 16'd1);

    // 2: two words back-to-back, valid and ready held high
    accepts = 0;
    s_data = 64'h8888_7777_6666_5555; s_last = 1'b0; s_valid = 1'b1;
    cycle();
    s_data = 64'hDDDD_CCCC_BBBB_AAAA; s_last = 1'b1;
    vcount = 0;
    guard = 0;
    while (accepts < 2 && guard < 20) begin
      if (o_valid) vcount++;
      cycle();
      guard++;
    end
    check("t2_accept_bound", accepts, 2);
    check("t2_accept_edge", guard, 4);
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o_valid) vcount++;
      cycle();
    end
    check("t2_contig_beats", vcount, 8);
    check("t2_drained", o_valid, 1'b0);

    // 3: backpressure 1,0,0,1,0,1,1 during a word
    s_data = 64'h0D0D_0C0C_0B0B_0A0A; s_last = 1'b0; s_valid = 1'b1;
    cycle();
    s_valid = 1'b0;
    bp_pat = 7'b1101001; // applied LSB first
    for (int i = 0; i < 7; i++) begin
      m_ready = bp_pat[i];
      cycle();
    end
    m_ready = 1'b1;
    cycle();
    check("t3_drained", q.size(), 0);

    // 4: reset after 2 beats of a word
    s_data = 64'h4444_3333_2222_1111; s_last = 1'b1; s_valid = 1'b1;
    cycle();
    s_data = 64'h9999_9999_9999_9999; s_valid = 1'b0;
    cycle(); cycle();
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_tvalid", v4, 1'b0);
    check("t4_async_frames", f4, 16'h0);
    check("t4_async_tready", r4, 1'b0);
    q.delete(); frames[0] = 16'd0; frames[1] = 16'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    s_data = 64'h4444_3333_2222_1111; s_last = 1'b0; s_valid = 1'b1;
    cycle();
    s_valid = 1'b0;
    check("t4_restart_lane0", o_data, 32'h1111);
    for (int i = 0; i < 4; i++) cycle();

    // 5: whole-word beats, one per cycle
    sel = 1'b1; m_ready = 1'b1;
    s_data = 64'h0000_0002_0001; s_last = 1'b0; s_valid = 1'b1;
    cycle();
    check("t5_word0", o_data, 32'h0002_0001);
    s_data = 64'h0000_0004_0003; s_last = 1'b1;
    cycle();
    s_valid = 1'b0;
    check("t5_word1", o_data, 32'h0004_0003);
    check("t5_word1_last", o_last, 1'b1);
    cycle();
    check("t5_frames", o_frames, 16'd1);
    check("t5_idle", o_valid, 1'b0);

    // 6: frame counter wrap
    rst_n = 1'b0; #1;
    q.delete(); frames[0] = 16'd0; frames[1] = 16'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    s_last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      s_data = {32'h0, $urandom};
      cycle();
    end
    s_valid = 1'b0;
    cycle(); cycle();
    check("t6_preload", o_frames, 16'hFFFF);
    s_data = 64'h0000_1234_5678; s_valid = 1'b1;
    cycle();
    s_valid = 1'b0;
    check("t6_wrap_data", o_data, 32'h1234_5678);
    cycle();
    check("t6_wrap", o_frames, 16'h0000);
    check("t6_other_frames", f4, 16'h0000);

    // Randomized traffic on both configurations
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 400; i++) begin
        s_valid = ($urandom_range(0, 2) != 0);
        s_data  = {$urandom, $urandom};
        s_last  = $urandom_range(0, 1) == 1;
        m_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
      s_valid = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
